// File: rtl/if_fetch_queue.sv
`default_nettype none
// if_fetch_queue: instruction-fetch reader with a small address/instruction FIFO.
// Issues one word read at a time over req/ack and flushes on redirect.
module if_fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [31:0]              redirect_addr,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            mem_req_q, mem_req_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     pc_mem_q   [DEPTH];

  logic            pop;
  logic            push;
  logic [AW:0]     count_pop;
  logic [31:0]     next_addr;
  logic [31:0]     redirect_word;

  // Bit 31 is the supervisor bit and never carries out of the increment.
  assign next_addr     = {fetch_addr_q[31], fetch_addr_q[30:0] + 31'd4};
  assign redirect_word = redirect_addr & 32'hFFFF_FFFC;
  assign pop           = (count_q != '0) && inst_ready;
  assign count_pop     = count_q - (pop ? CNT_ONE : '0);

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    push         = 1'b0;

    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_addr_d = redirect_word;
        end else if (count_pop < DEPTH_C) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_addr_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_addr_d = redirect_word;
          if (mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d   = DISCARD;
          end
        end else if (mem_ack) begin
          push         = 1'b1;
          fetch_addr_d = next_addr;
          // The new read reserves a slot, so it must still fit after this push.
          if ((count_pop + CNT_ONE) < DEPTH_C) begin
            mem_addr_d = next_addr;
          end else begin
            mem_req_d  = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_addr_d = redirect_word;
        end
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d = count_pop + (push ? CNT_ONE : '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_ADDR;
      mem_addr_q   <= RESET_ADDR;
      mem_req_q    <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= mem_rdata;
      pc_mem_q[wr_ptr_q]   <= fetch_addr_q;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// tb_if_fetch_queue: table-driven phases plus a scoreboard of expected fetched words.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  count;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        rd;
    logic [31:0] ra;
    logic        rdy;
    int          wt;
    int          cyc;
    int          ecnt;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  ent_t        exp_q[$];
  logic [31:0] exp_fetch;
  logic        prev_req, prev_acked, tainted;
  int          wcnt, n_req;
  int          n_vec, n_err;
  vec_t        tbl[16];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] inc_addr(input logic [31:0] a);
    return {a[31], a[30:0] + 31'd4};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_fetch  = 32'h0000_0000;
    prev_req   = 1'b0;
    prev_acked = 1'b0;
    tainted    = 1'b0;
    wcnt       = 0;
    n_req      = 0;
  endtask

  // One clock cycle: check state left by the last edge, then drive this cycle's inputs.
  task automatic tick(input logic rd, input logic [31:0] ra, input logic rdy, input int wt);
    logic nreq;
    @(negedge clk);
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("inst_pc", inst_pc, exp_q[0].pc);
      chk("inst", inst, exp_q[0].data);
    end
    chk("no_overrun", 32'((32'(count) + 32'(mem_req)) <= DEPTH), 32'd1);
    nreq = mem_req && (!prev_req || prev_acked);
    if (nreq) begin
      n_req++;
      wcnt    = 0;
      tainted = 1'b0;
      chk("req_addr", mem_addr, exp_fetch);
    end
    redirect      = rd;
    redirect_addr = ra;
    inst_ready    = rdy;
    mem_ack       = mem_req && (wcnt >= wt);
    mem_rdata     = mem_ack ? data_of(mem_addr) : 32'hDEAD_BEEF;
    if (mem_req) wcnt++;
    if (rd) begin
      exp_q.delete();
      exp_fetch = ra & 32'hFFFF_FFFC;
      if (mem_req && !mem_ack) tainted = 1'b1;
    end else begin
      if (inst_valid && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (mem_ack) begin
        if (!tainted) begin
          exp_q.push_back({exp_fetch, data_of(mem_addr)});
          exp_fetch = inc_addr(exp_fetch);
        end
        tainted = 1'b0;
      end
    end
    prev_req   = mem_req;
    prev_acked = mem_ack;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    reset         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'h0;
    mem_ack       = 1'b0;
    mem_rdata     = 32'h0;
    inst_ready    = 1'b0;

    //          rd    redirect_addr  rdy   wt cyc cnt req   mem_addr
    tbl[0]  = '{1'b0, 32'h0000_0000, 1'b1, 0, 20, 1, 1'b1, 32'h0000_0050};
    tbl[1]  = '{1'b0, 32'h0000_0000, 1'b0, 0, 10, 4, 1'b0, 32'h0000_0000};
    tbl[2]  = '{1'b0, 32'h0000_0000, 1'b1, 0, 1,  3, 1'b1, 32'h0000_005C};
    tbl[3]  = '{1'b0, 32'h0000_0000, 1'b0, 0, 3,  4, 1'b0, 32'h0000_0000};
    tbl[4]  = '{1'b0, 32'h0000_0000, 1'b1, 3, 1,  3, 1'b1, 32'h0000_0060};
    tbl[5]  = '{1'b1, 32'h8000_0004, 1'b0, 3, 1,  0, 1'b1, 32'h0000_0060};
    tbl[6]  = '{1'b0, 32'h0000_0000, 1'b0, 3, 3,  0, 1'b0, 32'h0000_0000};
    tbl[7]  = '{1'b0, 32'h0000_0000, 1'b1, 0, 2,  1, 1'b1, 32'h8000_0008};
    tbl[8]  = '{1'b1, 32'h0000_0100, 1'b1, 0, 1,  0, 1'b0, 32'h0000_0000};
    tbl[9]  = '{1'b0, 32'h0000_0000, 1'b1, 0, 3,  1, 1'b1, 32'h0000_0108};
    tbl[10] = '{1'b1, 32'h7FFF_FFFC, 1'b1, 0, 1,  0, 1'b0, 32'h0000_0000};
    tbl[11] = '{1'b0, 32'h0000_0000, 1'b1, 0, 3,  1, 1'b1, 32'h0000_0004};
    tbl[12] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 0, 1,  0, 1'b0, 32'h0000_0000};
    tbl[13] = '{1'b0, 32'h0000_0000, 1'b1, 0, 3,  1, 1'b1, 32'h8000_0004};
    tbl[14] = '{1'b1, 32'h0000_0013, 1'b1, 0, 1,  0, 1'b0, 32'h0000_0000};
    tbl[15] = '{1'b0, 32'h0000_0000, 1'b1, 0, 2,  1, 1'b1, 32'h0000_0014};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0000_0000);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].rd, tbl[i].ra, tbl[i].rdy, tbl[i].wt);
      for (int c = 1; c < tbl[i].cyc; c++) tick(1'b0, 32'h0, tbl[i].rdy, tbl[i].wt);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_mem_req", i), 32'(mem_req), 32'(tbl[i].ereq));
      if (tbl[i].ereq) chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].eaddr);
    end

    // Reset while a read is outstanding; a late ack must be ignored.
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    redirect   = 1'b0;
    inst_ready = 1'b0;
    mem_ack    = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    model_reset();
    reset = 1'b1;

    // Zero-wait memory: head valid two edges after release.
    tick(1'b0, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk("latency_valid", 32'(inst_valid), 32'd1);
    chk("latency_pc", inst_pc, 32'h0000_0000);
    chk("latency_inst", inst, data_of(32'h0000_0000));

    // Stalled decode: exactly DEPTH requests, then idle.
    for (int c = 0; c < 11; c++) tick(1'b0, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk("full_n_req", 32'(n_req), 32'd4);
    chk("full_count", 32'(count), 32'd4);
    chk("full_mem_req", 32'(mem_req), 32'd0);

    // One pop frees exactly one slot -> one request at 0x10.
    tick(1'b0, 32'h0, 1'b1, 0);
    for (int c = 0; c < 5; c++) tick(1'b0, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk("refill_n_req", 32'(n_req), 32'd5);
    chk("refill_count", 32'(count), 32'd4);
    chk("refill_mem_req", 32'(mem_req), 32'd0);
    chk("refill_tail_pc", exp_q[3].pc, 32'h0000_0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch reader for the pipelined CPU. It consumes the fetch address that the PC-update logic produces, issues word reads to instruction memory over a req/ack handshake, and buffers returned words with their addresses in a small FIFO for the decode stage. A redirect (branch, jump, jr, ILLOP/XADR exception vector) flushes the queue and restarts fetch at the new address. Any in-flight read is drained and its data dropped.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
RESET_ADDR, 32'h00000000, first fetch address after reset.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
redirect  in  1  one-cycle pulse: restart fetch at redirect_addr
redirect_addr  in  32  new fetch address; bits [1:0] ignored and forced to 00
mem_req  out  1  read request to instruction memory (registered)
mem_addr  out  32  read word address (registered, stable while mem_req=1)
mem_ack  in  1  read complete; mem_rdata valid in the same cycle
mem_rdata  in  32  instruction word
inst_valid  out  1  queue head valid (queue not empty)
inst  out  32  instruction at queue head
inst_pc  out  32  address of inst
inst_ready  in  1  decode accepts head; pop when inst_valid & inst_ready
count  out  log2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (async, reset=0): state=IDLE; fetch_addr=RESET_ADDR; mem_req=0; mem_addr=RESET_ADDR; queue empty; count=0; inst_valid=0. inst and inst_pc are don't-care while inst_valid=0.
- Address increment: next = {fetch_addr[31], fetch_addr[30:0]+4}. Bit 31 (supervisor bit) is preserved.
  - 32'h7FFFFFFC -> 32'h00000000
  - 32'hFFFFFFFC -> 32'h80000000
- At most one read outstanding.
- Handshake: once mem_req=1, mem_req and mem_addr hold until the cycle mem_ack=1. mem_ack while mem_req=0 is ignored.
- States:
  - IDLE: if !redirect and count_next < DEPTH: mem_req<=1, mem_addr<=fetch_addr, go REQ. count_next is the occupancy after this cycle's pop.
  - REQ, mem_ack=1 and no redirect:
    - push {fetch_addr, mem_rdata}; fetch_addr<=next.
    - If occupancy after push and pop < DEPTH: issue next read back-to-back (mem_addr<=next, mem_req stays 1, stay REQ).
    - Otherwise mem_req<=0, go IDLE.
  - REQ, redirect=1 and mem_ack=1: drop data, flush queue, fetch_addr<=redirect_addr, mem_req<=0, go IDLE.
  - REQ, redirect=1 and mem_ack=0: flush queue, fetch_addr<=redirect_addr, go DISCARD. mem_req/mem_addr are held; the request is not withdrawn.
  - DISCARD: hold mem_req until mem_ack; data is dropped; then mem_req<=0, go IDLE. A further redirect here only updates fetch_addr.
- Redirect priority: redirect beats same-cycle pop and push.
  - Flush result: count=0 and inst_valid=0 in the next cycle.
  - First post-redirect request: mem_req rises no earlier than 1 cycle after redirect.
- Full: no request issued while occupancy (including the reserved in-flight slot) would reach DEPTH. The FIFO can never overflow.
- Simultaneous pop and push: count unchanged; the pushed entry lands behind the remaining entries.
- Empty: inst_valid=0; inst_ready is ignored.
- Latency: with zero-wait memory (ack in the first REQ cycle), the first word is at the head 2 cycles after reset release. Steady-state throughput is 1 word/cycle.
- Reset mid-transaction: mem_req drops immediately and asynchronously; any late ack is ignored.

Test Plan:
1. Reset release, memory acks every cycle, inst_ready=1 -> mem_addr 0,4,8,C…; inst/inst_pc pairs match in order; count never exceeds 1.
2. inst_ready=0, DEPTH=4 -> exactly 4 requests issued, count=4, mem_req=0. One pop -> exactly one new request, at address 0x10.
3. Redirect to 0x80000004 while REQ waits (ack delayed 3 cycles) -> queue flushed next cycle; old mem_addr held until ack; that data never appears; next request is 0x80000004.
4. Redirect coincident with mem_ack and with a pop -> no push; count=0; fetch resumes at redirect_addr with no duplicate or lost entries.
5. Redirect to 0x7FFFFFFC, then to 0xFFFFFFFC -> successor addresses are 0x00000000 and 0x80000000 respectively. Redirect_addr 0x00000013 fetches at 0x00000010.
6. Assert reset while mem_req=1 -> mem_req=0 and count=0 asynchronously. After release, fetch restarts at RESET_ADDR.
